// File: rtl/pci_master_if.sv
// Local command port plus PCI initiator bus pins of pci_master, split into out/oe pairs.
// The master modport is the initiator's view; slave is the environment's view.
interface pci_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic [1:0]  status;
  logic        req;
  logic        gnt;
  logic        frame_in;
  logic        irdy_in;
  logic        trdy;
  logic        devsel;
  logic        stop;
  logic        frame_out;
  logic        frame_oe;
  logic        irdy_out;
  logic        irdy_oe;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [31:0] ad_in;
  logic [3:0]  cbe_out;
  logic        cbe_oe;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
    input  gnt, frame_in, irdy_in, trdy, devsel, stop, ad_in,
    output cmd_ready, wr_pop, rd_data, rd_valid, done, status, req,
    output frame_out, frame_oe, irdy_out, irdy_oe, ad_out, ad_oe, cbe_out, cbe_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
    output gnt, frame_in, irdy_in, trdy, devsel, stop, ad_in,
    input  cmd_ready, wr_pop, rd_data, rd_valid, done, status, req,
    input  frame_out, frame_oe, irdy_out, irdy_oe, ad_out, ad_oe, cbe_out, cbe_oe
  );
endinterface

// File: rtl/pci_master.sv
// PCI bus initiator: requests the bus, runs one address phase and a burst of memory
// read/write data phases, handles target disconnect and master abort, reports status.
module pci_master #(
  parameter int MAX_BURST      = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic clk,
  input  logic rst,
  pci_master_if.master bus
);

  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_FIN, S_TURN} state_t;

  state_t         state_r, state_nxt_s;
  logic           write_r, write_nxt_s;
  logic [31:0]    addr_r, addr_nxt_s;
  logic [3:0]     remaining_r, remaining_nxt_s;
  logic [TW-1:0]  timer_r, timer_nxt_s;
  logic [1:0]     status_r, status_nxt_s;
  logic [31:0]    rd_data_r;
  logic           rd_valid_r;
  logic           rd_capture_s, xfer_s, last_s;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0) begin
      return 4'd1;
    end else if (len > 4'(MAX_BURST)) begin
      return 4'(MAX_BURST);
    end else begin
      return len;
    end
  endfunction

  assign xfer_s = !bus.trdy && !bus.devsel;
  assign last_s = (remaining_r == 4'd1);

  // Next-state, datapath updates and bus outputs decoded from the current state.
  always_comb begin
    state_nxt_s     = state_r;
    write_nxt_s     = write_r;
    addr_nxt_s      = addr_r;
    remaining_nxt_s = remaining_r;
    timer_nxt_s     = timer_r;
    status_nxt_s    = status_r;
    rd_capture_s    = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.wr_pop      = 1'b0;
    bus.done        = 1'b0;
    bus.req         = 1'b1;
    bus.frame_out   = 1'b1;
    bus.frame_oe    = 1'b0;
    bus.irdy_out    = 1'b1;
    bus.irdy_oe     = 1'b0;
    bus.ad_out      = 32'h0000_0000;
    bus.ad_oe       = 1'b0;
    bus.cbe_out     = 4'b0000;
    bus.cbe_oe      = 1'b0;
    case (state_r)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          write_nxt_s     = bus.cmd_write;
          addr_nxt_s      = bus.cmd_addr & 32'hFFFF_FFFC;
          remaining_nxt_s = clamp_len(bus.cmd_len);
          status_nxt_s    = 2'b00;
          state_nxt_s     = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        bus.req = 1'b0;
        if (!bus.gnt && bus.frame_in && bus.irdy_in) begin
          state_nxt_s = S_ADDR;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_ADDR: begin
        bus.frame_oe  = 1'b1;
        bus.frame_out = 1'b0;
        bus.ad_oe     = 1'b1;
        bus.ad_out    = addr_r;
        bus.cbe_oe    = 1'b1;
        bus.cbe_out   = write_r ? 4'b0111 : 4'b0110;
        timer_nxt_s   = '0;
        state_nxt_s   = S_DATA;
      end
      S_DATA: begin
        bus.frame_oe  = 1'b1;
        bus.frame_out = last_s;
        bus.irdy_oe   = 1'b1;
        bus.irdy_out  = 1'b0;
        bus.cbe_oe    = 1'b1;
        bus.ad_oe     = write_r;
        if (write_r) begin
          bus.ad_out = bus.wr_data;
        end else begin
          bus.ad_out = 32'h0000_0000;
        end
        if (xfer_s) begin
          remaining_nxt_s = remaining_r - 4'd1;
          addr_nxt_s      = addr_r + 32'd4;
          bus.wr_pop      = write_r;
          rd_capture_s    = !write_r;
        end else begin
          remaining_nxt_s = remaining_r;
        end
        if (bus.devsel) begin
          timer_nxt_s = timer_r + TW'(1);
        end else begin
          timer_nxt_s = '0;
        end
        // Exit priority: normal completion, then target stop, then DEVSEL# timeout.
        if (xfer_s && last_s) begin
          status_nxt_s = 2'b00;
          state_nxt_s  = S_TURN;
        end else if (!bus.stop && !bus.devsel) begin
          status_nxt_s = 2'b10;
          state_nxt_s  = last_s ? S_TURN : S_FIN;
        end else if (bus.devsel && (timer_r == TW'(DEVSEL_TIMEOUT - 1))) begin
          status_nxt_s = 2'b01;
          state_nxt_s  = last_s ? S_TURN : S_FIN;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_FIN: begin
        bus.frame_oe  = 1'b1;
        bus.frame_out = 1'b1;
        bus.irdy_oe   = 1'b1;
        bus.irdy_out  = 1'b0;
        bus.cbe_oe    = 1'b1;
        state_nxt_s   = S_TURN;
      end
      S_TURN: begin
        bus.frame_oe  = 1'b1;
        bus.irdy_oe   = 1'b1;
        bus.done      = 1'b1;
        state_nxt_s   = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, transaction context and registered read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      write_r     <= 1'b0;
      addr_r      <= 32'h0000_0000;
      remaining_r <= 4'd0;
      timer_r     <= '0;
      status_r    <= 2'b00;
      rd_data_r   <= 32'h0000_0000;
      rd_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      write_r     <= write_nxt_s;
      addr_r      <= addr_nxt_s;
      remaining_r <= remaining_nxt_s;
      timer_r     <= timer_nxt_s;
      status_r    <= status_nxt_s;
      rd_valid_r  <= rd_capture_s;
      if (rd_capture_s) begin
        rd_data_r <= bus.ad_in;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.status   = status_r;

endmodule

// File: tb/tb_pci_master.sv
// Directed and randomized transactions against pci_master with a transaction-level
// target script and expected outcome computed from the bus rules.
module tb_pci_master;
  localparam int MAXB = 8;
  localparam int TMO  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pci_master_if bus();

  pci_master #(.MAX_BURST(MAXB), .DEVSEL_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rd_pulses = 0;
  int done_pulses = 0;

  // Target script and expected per-cycle behaviour for one transaction
  logic        dv_a [64];
  logic        tr_a [64];
  logic        st_a [64];
  logic [31:0] adi_a [64];
  logic        e_last [64];
  logic        e_xfer [64];
  int          e_idx [64];
  logic [31:0] wr_words [16];
  int          ncyc, exp_beats;
  logic [1:0]  exp_status;
  logic        exp_fin;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) rd_pulses++;
    if (bus.done === 1'b1) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_len = 4'd0;
    bus.wr_data = 32'h0; bus.gnt = 1'b1; bus.frame_in = 1'b1; bus.irdy_in = 1'b1;
    bus.trdy = 1'b1; bus.devsel = 1'b1; bus.stop = 1'b1; bus.ad_in = 32'h0;
  endtask

  // mode 0: random waits and late DEVSEL#, 1: stop on stop_beat, 2: no DEVSEL#, 3: one wait on wait_beat
  task automatic plan(input int mode, input logic wr, input logic [3:0] len, input int stop_beat,
                      input bit stop_xfer, input int wait_beat, input bit seq);
    int rem, beats, tmr, c, dly;
    bit waited, fin_now;
    logic d, t, s, last, xfer;
    rem = (len == 4'd0) ? 1 : ((int'(len) > MAXB) ? MAXB : int'(len));
    beats = 0; tmr = 0; c = 0; waited = 1'b0; fin_now = 1'b0;
    dly = (mode == 0) ? int'($urandom_range(0, 3)) : 0;
    exp_fin = 1'b0; exp_status = 2'b00;
    while (!fin_now) begin
      d = 1'b0; t = 1'b0; s = 1'b1;
      case (mode)
        0: if (c < dly) begin d = 1'b1; t = 1'b1; end
           else t = (c < 40) && ($urandom_range(0, 3) == 0);
        1: if (beats == stop_beat) begin s = 1'b0; t = !stop_xfer; end
        2: begin d = 1'b1; t = 1'b1; end
        default: if (beats == wait_beat && !waited) begin t = 1'b1; waited = 1'b1; end
      endcase
      last = (rem == 1);
      xfer = !d && !t;
      dv_a[c] = d; tr_a[c] = t; st_a[c] = s;
      adi_a[c] = seq ? (32'hA0 + 32'(beats)) : $urandom;
      e_last[c] = last; e_xfer[c] = xfer; e_idx[c] = beats;
      if (xfer) begin beats++; rem--; end
      if (xfer && last) begin
        exp_status = 2'b00; fin_now = 1'b1;
      end else if (!s && !d) begin
        exp_status = 2'b10; exp_fin = !last; fin_now = 1'b1;
      end else if (d) begin
        tmr++;
        if (tmr == TMO) begin exp_status = 2'b01; exp_fin = !last; fin_now = 1'b1; end
      end else begin
        tmr = 0;
      end
      c++;
    end
    ncyc = c;
    exp_beats = beats;
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input int mode, input int stop_beat, input bit stop_xfer,
                         input int wait_beat, input bit seq, input int busy,
                         input int busy_kind, input logic [31:0] w0);
    int k, rd0, dn0;
    logic prev_rd;
    logic [31:0] prev_val;
    plan(mode, wr, len, stop_beat, stop_xfer, wait_beat, seq);
    wr_words[0] = w0;
    for (int i = 1; i < 16; i++) wr_words[i] = $urandom;
    rd0 = rd_pulses; dn0 = done_pulses;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = len;
    bus.gnt = 1'b1;
    #1 check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int b = 0; b < busy; b++) begin
      k = (busy_kind < 0) ? int'($urandom_range(0, 2)) : busy_kind;
      bus.gnt = (k == 0); bus.frame_in = (k != 1); bus.irdy_in = (k != 2);
      #1 check("req_busy", {bus.req, bus.frame_oe, bus.cmd_ready}, 3'b000);
      @(negedge clk);
    end
    bus.gnt = 1'b0; bus.frame_in = 1'b1; bus.irdy_in = 1'b1;
    #1 check("req_go", bus.req, 1'b0);
    @(negedge clk);
    bus.gnt = $urandom_range(0, 1);
    #1 check("addr_ad", bus.ad_out, addr & 32'hFFFF_FFFC);
    check("addr_cbe", bus.cbe_out, wr ? 4'b0111 : 4'b0110);
    check("addr_ctl", {bus.frame_oe, bus.frame_out, bus.ad_oe, bus.cbe_oe, bus.req, bus.irdy_oe},
          6'b101110);
    prev_rd = 1'b0; prev_val = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.devsel = dv_a[c]; bus.trdy = tr_a[c]; bus.stop = st_a[c]; bus.ad_in = adi_a[c];
      bus.wr_data = wr_words[e_idx[c]];
      bus.gnt = $urandom_range(0, 1);
      #1 check("data_irdy", {bus.irdy_oe, bus.irdy_out, bus.cbe_out}, 6'b100000);
      check("data_frame", bus.frame_out, e_last[c]);
      check("data_wr_pop", bus.wr_pop, wr && e_xfer[c]);
      check("data_ad_oe", bus.ad_oe, wr);
      if (wr) check("data_ad_out", bus.ad_out, wr_words[e_idx[c]]);
      check("rd_valid", bus.rd_valid, prev_rd);
      if (prev_rd) check("rd_data", bus.rd_data, prev_val);
      prev_rd = !wr && e_xfer[c]; prev_val = adi_a[c];
    end
    @(negedge clk);
    bus.devsel = 1'b1; bus.trdy = 1'b1; bus.stop = 1'b1; bus.gnt = 1'b1;
    if (exp_fin) begin
      #1 check("fin_ctl", {bus.frame_oe, bus.frame_out, bus.irdy_oe, bus.irdy_out, bus.done}, 5'b11100);
      check("fin_wr_pop", bus.wr_pop, 1'b0);
      check("rd_valid_fin", bus.rd_valid, prev_rd);
      if (prev_rd) check("rd_data_fin", bus.rd_data, prev_val);
      prev_rd = 1'b0;
      @(negedge clk);
    end
    #1 check("turn_ctl", {bus.done, bus.frame_oe, bus.frame_out, bus.irdy_oe, bus.irdy_out,
                          bus.ad_oe, bus.cbe_oe}, 7'b1111100);
    check("turn_status", bus.status, exp_status);
    check("rd_valid_turn", bus.rd_valid, prev_rd);
    if (prev_rd) check("rd_data_turn", bus.rd_data, prev_val);
    @(negedge clk);
    #1 check("idle_after", {bus.done, bus.cmd_ready, bus.req, bus.frame_oe, bus.irdy_oe}, 5'b01100);
    check("status_hold", bus.status, exp_status);
    check("rd_pulse_count", rd_pulses - rd0, wr ? 0 : exp_beats);
    check("done_count", done_pulses - dn0, 1);
  endtask

  initial begin
    int dn0;
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_state", {bus.req, bus.frame_oe, bus.irdy_oe, bus.ad_oe, bus.cbe_oe, bus.cmd_ready,
                             bus.done, bus.rd_valid, bus.wr_pop, bus.frame_out, bus.irdy_out}, 11'b10000100011);
    check("reset_status", bus.status, 2'b00);
    rst = 1'b0;

    // single write
    run_txn(1'b1, 32'h0000_1000, 4'd1, 3, 0, 1'b0, -1, 1'b0, 0, 1, 32'hDEAD_BEEF);
    // 4-beat read with one wait on beat 2
    run_txn(1'b0, 32'h0000_2000, 4'd4, 3, 0, 1'b0, 1, 1'b1, 0, 1, 32'h0);
    // master abort
    run_txn(1'b0, 32'h0000_2400, 4'd2, 2, 0, 1'b0, -1, 1'b0, 0, 1, 32'h0);
    // bus busy for 3 cycles with grant present
    run_txn(1'b0, 32'h0000_2800, 4'd1, 3, 0, 1'b0, -1, 1'b0, 3, 1, 32'h0);
    // disconnect with data on beat 2, then retry with cmd_len 0
    run_txn(1'b1, 32'h0000_3000, 4'd4, 1, 1, 1'b1, -1, 1'b0, 0, 1, 32'h1111_2222);
    run_txn(1'b1, 32'h0000_3008, 4'd0, 3, 0, 1'b0, -1, 1'b0, 0, 1, 32'h3333_4444);
    // clamp above MAX_BURST, unaligned address
    run_txn(1'b0, 32'h0000_5003, 4'd15, 3, 0, 1'b0, -1, 1'b1, 1, -1, 32'h0);

    // reset in the middle of DATA
    dn0 = done_pulses;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h4000; bus.cmd_len = 4'd8;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.gnt = 1'b0;
    @(negedge clk);
    bus.gnt = 1'b1; bus.devsel = 1'b0; bus.trdy = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("pre_reset_data", {bus.irdy_oe, bus.irdy_out}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    #1 check("mid_reset", {bus.req, bus.frame_oe, bus.irdy_oe, bus.ad_oe, bus.cbe_oe, bus.cmd_ready,
                           bus.done, bus.rd_valid}, 8'b10000100);
    @(negedge clk);
    rst = 1'b0; bus.devsel = 1'b1; bus.trdy = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset_no_done", done_pulses - dn0, 0);
    check("reset_idle", {bus.cmd_ready, bus.req, bus.frame_oe}, 3'b110);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              -1, 1'b0, int'($urandom_range(0, 3)), -1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
